// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO register bus between the CPU pipeline and the
// multi-cycle multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one result bit per cycle,
// sign correction in a final cycle, MTHI/MTLO writes while idle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_res, neg_rem, b_zero;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   p_hi, p_lo;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               done_r, dz_r;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.dz   = dz_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mag_a    = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b    = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    add_sum  = {1'b0, p_hi} + {1'b0, mc};
    // Restoring step: the borrow out (bit WIDTH) means the divisor did not fit.
    trial    = {p_hi, p_lo[WIDTH-1]} - {1'b0, mc};
    prod     = {p_hi, p_lo};
    prod_neg = -prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_reg   <= '0;
      mc      <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= CNT_W'(WIDTH - 1);
            is_div  <= bus.op[1];
            neg_res <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem <= bus.op[0] & bus.a[WIDTH-1];
            b_zero  <= (bus.b == '0);
            a_reg   <= bus.a;
            dz_r    <= 1'b0;
            p_hi    <= '0;
            // Divide shifts the dividend out of p_lo; multiply shifts the multiplier.
            if (bus.op[1]) begin
              p_lo <= mag_a;
              mc   <= mag_b;
            end else begin
              p_lo <= mag_b;
              mc   <= mag_a;
            end
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            if (!trial[WIDTH]) begin
              p_hi <= trial[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end else if (p_lo[0]) begin
            {p_hi, p_lo} <= {add_sum, p_lo[WIDTH-1:1]};
          end else begin
            {p_hi, p_lo} <= {1'b0, p_hi, p_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_r <= 1'b1;
          if (is_div) begin
            if (b_zero) begin
              lo_r <= '1;
              hi_r <= a_reg;
              dz_r <= 1'b1;
            end else begin
              lo_r <= neg_res ? -p_lo : p_lo;
              hi_r <= neg_rem ? -p_hi : p_hi;
            end
          end else begin
            {hi_r, lo_r} <= neg_res ? prod_neg : prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32: result table plus
// hand-written sequences for busy interactions, MTHI/MTLO and reset abort.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic reset;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs [13];

  int applied    = 0;
  int miscompares = 0;
  int cyc   = 0;
  int dones = 0;
  int busies = 0;
  int hold_bad = 0;
  logic [W-1:0] hold_hi, hold_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs 1 ns after the rising edge; inputs are driven at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done) dones++;
    if (bus.busy) busies++;
    if (bus.busy && (bus.hi !== hold_hi || bus.lo !== hold_lo)) hold_bad++;
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic hw, input logic [W-1:0] wd);
    hold_hi   = bus.hi;
    hold_lo   = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.hi_we = hw;
    bus.wdata = wd;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.op    = ~op;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(input int c_start, output int lat);
    while (!bus.done && (cyc - c_start) < 100) tick();
    lat = cyc - c_start - 1;
  endtask

  initial begin
    int c0, b0, d0, h0, lat;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFFFF00, 32'h00000000, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    hold_hi = '0; hold_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset dz",   {63'd0, bus.dz},   64'd0);
    check("reset hi",   {32'd0, bus.hi},   64'd0);
    check("reset lo",   {32'd0, bus.lo},   64'd0);
    reset = 1'b0;

    // Table: each op is launched on the first edge after the previous one finishes.
    for (int i = 0; i < 13; i++) begin
      c0 = cyc; b0 = busies; d0 = dones; h0 = hold_bad;
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, '0);
      wait_done(c0, lat);
      check($sformatf("v%0d latency", i), 64'(lat), 64'd33);
      check($sformatf("v%0d busy cycles", i), 64'(busies - b0), 64'd33);
      check($sformatf("v%0d busy at done", i), {63'd0, bus.busy}, 64'd0);
      check($sformatf("v%0d hi", i), {32'd0, bus.hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d lo", i), {32'd0, bus.lo}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d dz", i), {63'd0, bus.dz}, {63'd0, vecs[i].dz});
      check($sformatf("v%0d hilo held", i), 64'(hold_bad - h0), 64'd0);
      tick();
      check($sformatf("v%0d done pulses", i), 64'(dones - d0), 64'd1);
    end

    // start + hi_we while busy are ignored.
    c0 = cyc; d0 = dones;
    launch(2'b00, 32'd2, 32'd3, 1'b0, '0);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd5; bus.b = 32'd0;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    wait_done(c0, lat);
    check("busy-start latency", 64'(lat), 64'd33);
    check("busy-start hi", {32'd0, bus.hi}, 64'd0);
    check("busy-start lo", {32'd0, bus.lo}, 64'd6);
    check("busy-start dz", {63'd0, bus.dz}, 64'd0);
    repeat (40) tick();
    check("busy-start single done", 64'(dones - d0), 64'd1);
    check("busy-start stays idle", {63'd0, bus.busy}, 64'd0);

    // MTHI / MTLO in idle.
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.hi_we = 1'b0;
    check("mthi hi", {32'd0, bus.hi}, 64'h12345678);
    check("mthi lo untouched", {32'd0, bus.lo}, 64'd6);
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo lo", {32'd0, bus.lo}, 64'hCAFEF00D);
    check("mtlo hi untouched", {32'd0, bus.hi}, 64'h12345678);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BADBEEF;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("both strobes hi", {32'd0, bus.hi}, 64'h0BADBEEF);
    check("both strobes lo", {32'd0, bus.lo}, 64'h0BADBEEF);

    // start together with hi_we in idle: the write is dropped.
    c0 = cyc;
    launch(2'b00, 32'd2, 32'd3, 1'b1, 32'hFFFFFFFF);
    check("start wins hi held", {32'd0, bus.hi}, 64'h0BADBEEF);
    check("start wins busy", {63'd0, bus.busy}, 64'd1);
    wait_done(c0, lat);
    check("start wins latency", 64'(lat), 64'd33);
    check("start wins hi", {32'd0, bus.hi}, 64'd0);
    check("start wins lo", {32'd0, bus.lo}, 64'd6);
    tick();

    // Reset mid-divide aborts with no later done.
    bus.hi_we = 1'b1; bus.wdata = 32'h55AA55AA;
    tick();
    bus.hi_we = 1'b0;
    launch(2'b10, 32'd1000, 32'd3, 1'b0, '0);
    repeat (9) tick();
    check("pre-abort busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort hi", {32'd0, bus.hi}, 64'd0);
    check("abort lo", {32'd0, bus.lo}, 64'd0);
    hold_hi = '0; hold_lo = '0;
    repeat (2) tick();
    reset = 1'b0;
    d0 = dones;
    repeat (40) tick();
    check("abort no done", 64'(dones - d0), 64'd0);
    check("abort idle", {63'd0, bus.busy}, 64'd0);
    check("abort hi stays", {32'd0, bus.hi}, 64'd0);

    // First start right after reset release.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c0 = cyc;
    launch(2'b00, 32'd2, 32'd3, 1'b0, '0);
    check("post-reset start busy", {63'd0, bus.busy}, 64'd1);
    wait_done(c0, lat);
    check("post-reset latency", 64'(lat), 64'd33);
    check("post-reset lo", {32'd0, bus.lo}, 64'd6);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
